// File: rtl/sobel_stream_filter.sv
// sobel_stream_filter: streaming 3x3 Sobel edge detector with internal line buffers
// Ports: clk, reset (sync, active-high); in_valid/in_ready/in_pixel/in_sof input stream;
//        out_valid/out_pixel/out_sof/out_eol/out_eof output stream (no backpressure).
// Build option: define SOBEL_THRESH_EN for a binary edge map (mag >= THRESH -> all ones).
module sobel_stream_filter #(
  parameter int H_PIXELS = 640,
  parameter int V_LINES  = 480,
  parameter int PIX_W    = 8,
  parameter int THRESH   = 128
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PIX_W-1:0] in_pixel,
  input  logic             in_sof,
  output logic             out_valid,
  output logic [PIX_W-1:0] out_pixel,
  output logic             out_sof,
  output logic             out_eol,
  output logic             out_eof
);
  localparam int NPIX = H_PIXELS * V_LINES;
  localparam int JW = $clog2(NPIX + H_PIXELS + 2);
  localparam int CW = $clog2(H_PIXELS);
  localparam int RW = $clog2(V_LINES);
  localparam logic [JW-1:0] J_LAST = JW'(NPIX - 1);
  localparam logic [JW-1:0] J_END = JW'(NPIX + H_PIXELS);
  localparam logic [JW-1:0] J_EMIT = JW'(H_PIXELS + 1);
  localparam logic [CW-1:0] C_LAST = CW'(H_PIXELS - 1);
  localparam logic [RW-1:0] R_LAST = RW'(V_LINES - 1);
  localparam logic [PIX_W+2:0] PMAX = {3'b000, {PIX_W{1'b1}}};
  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;
  state_t state_q, state_d;
  logic [JW-1:0] j_q, jcur;
  logic [CW-1:0] jc_q, ccur, oc_q;
  logic [RW-1:0] orow_q;
  logic start, take, adv, emit;
  logic [PIX_W-1:0] pix;
  logic [PIX_W-1:0] lb0_q [H_PIXELS];
  logic [PIX_W-1:0] lb1_q [H_PIXELS];
  logic [PIX_W-1:0] w_q [3][3];
  logic [PIX_W-1:0] w_d [3][3];
  logic v1_q, b1_q, sof1_q, eol1_q, eof1_q;
  logic signed [PIX_W+2:0] p [3][3];
  logic signed [PIX_W+2:0] gx, gy;
  logic [PIX_W+2:0] ax, ay, mag;
  logic [PIX_W-1:0] res;
  logic v2_q, sof2_q, eol2_q, eof2_q;
  logic [PIX_W-1:0] pix2_q;
  // An in_sof outside FLUSH always (re)starts a frame at index 0; phantom zeros feed FLUSH.
  always_comb begin
    start = (state_q != FLUSH) & in_valid & in_sof;
    take = (state_q == RUN) & in_valid;
    adv = start | take | (state_q == FLUSH);
    jcur = start ? '0 : j_q;
    ccur = start ? '0 : jc_q;
    pix = (state_q == FLUSH) ? '0 : in_pixel;
    emit = adv & (jcur >= J_EMIT);
  end
  always_ff @(posedge clk)
    if (reset) state_q <= IDLE;
    else state_q <= state_d;
  always_comb
    state_d = start ? RUN :
              (take & (jcur == J_LAST)) ? FLUSH :
              ((state_q == FLUSH) & (jcur == J_END)) ? IDLE : state_q;
  always_comb in_ready = (state_q != FLUSH);
  // Window shifts left; column 2 takes two-lines-ago, previous line, current pixel.
  always_comb begin
    for (int r = 0; r < 3; r++) begin
      w_d[r][0] = start ? '0 : w_q[r][1];
      w_d[r][1] = start ? '0 : w_q[r][2];
    end
    w_d[0][2] = lb0_q[ccur];
    w_d[1][2] = lb1_q[ccur];
    w_d[2][2] = pix;
  end
  always_ff @(posedge clk)
    if (adv) begin
      lb1_q[ccur] <= pix;
      lb0_q[ccur] <= lb1_q[ccur];
    end
  always_ff @(posedge clk)
    if (reset) begin
      j_q <= '0;
      jc_q <= '0;
      oc_q <= '0;
      orow_q <= '0;
      w_q <= '{default: '0};
      v1_q <= 1'b0;
      b1_q <= 1'b0;
      sof1_q <= 1'b0;
      eol1_q <= 1'b0;
      eof1_q <= 1'b0;
    end else begin
      v1_q <= emit;
      if (adv) begin
        j_q <= jcur + 1'b1;
        jc_q <= (ccur == C_LAST) ? '0 : ccur + 1'b1;
        w_q <= w_d;
      end
      if (start) begin
        oc_q <= '0;
        orow_q <= '0;
      end else if (emit) begin
        oc_q <= (oc_q == C_LAST) ? '0 : oc_q + 1'b1;
        orow_q <= (oc_q == C_LAST) ? orow_q + 1'b1 : orow_q;
      end
      if (emit) begin
        b1_q <= (orow_q == '0) | (orow_q == R_LAST) | (oc_q == '0) | (oc_q == C_LAST);
        sof1_q <= (orow_q == '0) & (oc_q == '0);
        eol1_q <= (oc_q == C_LAST);
        eof1_q <= (oc_q == C_LAST) & (orow_q == R_LAST);
      end
    end
  always_comb begin
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        p[r][c] = $signed({3'b000, w_q[r][c]});
    gx = p[0][2] + (p[1][2] <<< 1) + p[2][2] - p[0][0] - (p[1][0] <<< 1) - p[2][0];
    gy = p[2][0] + (p[2][1] <<< 1) + p[2][2] - p[0][0] - (p[0][1] <<< 1) - p[0][2];
    ax = gx[PIX_W+2] ? $unsigned(-gx) : $unsigned(gx);
    ay = gy[PIX_W+2] ? $unsigned(-gy) : $unsigned(gy);
    mag = ax + ay;
`ifdef SOBEL_THRESH_EN
    res = b1_q ? '0 : (mag >= (PIX_W+3)'(THRESH)) ? '1 : '0;
`else
    res = b1_q ? '0 : (mag > PMAX) ? '1 : mag[PIX_W-1:0];
`endif
  end
  // A restart also drops whatever sits in the window stage.
  always_ff @(posedge clk)
    if (reset) begin
      v2_q <= 1'b0;
      pix2_q <= '0;
      sof2_q <= 1'b0;
      eol2_q <= 1'b0;
      eof2_q <= 1'b0;
    end else begin
      v2_q <= v1_q & ~start;
      pix2_q <= (v1_q & ~start) ? res : '0;
      sof2_q <= v1_q & ~start & sof1_q;
      eol2_q <= v1_q & ~start & eol1_q;
      eof2_q <= v1_q & ~start & eof1_q;
    end
  assign out_valid = v2_q;
  assign out_pixel = pix2_q;
  assign out_sof = sof2_q;
  assign out_eol = eol2_q;
  assign out_eof = eof2_q;
endmodule

// File: tb/tb_sobel_stream_filter.sv
// tb_sobel_stream_filter: scoreboard bench for sobel_stream_filter at 8x6
module tb_sobel_stream_filter;
  localparam int H = 8;
  localparam int V = 6;
  localparam int N = H * V;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [7:0] in_pixel = '0;
  logic in_sof = 1'b0;
  logic out_valid, out_sof, out_eol, out_eof;
  logic [7:0] out_pixel;
  int checks = 0;
  int errors = 0;
  int img [N];
  logic [10:0] sb [$];
  bit ign = 1'b0;
  int n_out = 0;
  int nrdy = 0;
  int cyc = 0;
  int t_k = 0;
  sobel_stream_filter #(.H_PIXELS(H), .V_LINES(V), .PIX_W(8), .THRESH(128)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_pixel(in_pixel), .in_sof(in_sof), .out_valid(out_valid), .out_pixel(out_pixel),
    .out_sof(out_sof), .out_eol(out_eol), .out_eof(out_eof)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  always @(negedge clk) begin
    if (!in_ready) nrdy++;
    if (!reset && out_valid && !ign) begin
      logic [10:0] e;
      n_out++;
      if (out_sof) check("latency", cyc - t_k, 2);
      if (sb.size() == 0) check("extra_output", 1, 0);
      else begin
        e = sb.pop_front();
        check("pixel", out_pixel, e[10:3]);
        check("sof", out_sof, e[2]);
        check("eol", out_eol, e[1]);
        check("eof", out_eof, e[0]);
      end
    end
  end
  task automatic make_step(input int lo, input int hi);
    for (int r = 0; r < V; r++)
      for (int c = 0; c < H; c++)
        img[r*H+c] = (c >= 4) ? hi : lo;
  endtask
  function automatic int px(input int r, input int c);
    return img[r*H+c];
  endfunction
  task automatic push_expected();
    for (int r = 0; r < V; r++)
      for (int c = 0; c < H; c++) begin
        int gx, gy, m;
        m = 0;
        if (r > 0 && r < V-1 && c > 0 && c < H-1) begin
          gx = (px(r-1,c+1) + 2*px(r,c+1) + px(r+1,c+1)) - (px(r-1,c-1) + 2*px(r,c-1) + px(r+1,c-1));
          gy = (px(r+1,c-1) + 2*px(r+1,c) + px(r+1,c+1)) - (px(r-1,c-1) + 2*px(r-1,c) + px(r-1,c+1));
          m = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
          if (m > 255) m = 255;
`ifdef SOBEL_THRESH_EN
          m = (m >= 128) ? 255 : 0;
`endif
        end
        sb.push_back({8'(m), r == 0 && c == 0, c == H-1, r == V-1 && c == H-1});
      end
  endtask
  task automatic send(input int pix, input bit sof);
    int t = 0;
    while (!in_ready && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    if (t == 100) check("ready_timeout", 0, 1);
    in_valid = 1'b1;
    in_pixel = 8'(pix);
    in_sof = sof;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_sof = 1'b0;
  endtask
  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 1000) begin
      @(negedge clk);
      t++;
    end
    check("drain", sb.size(), 0);
    repeat (15) @(posedge clk);
    #1;
  endtask
  task automatic drive_frame(input bit gaps);
    push_expected();
    n_out = 0;
    for (int k = 0; k < N; k++) begin
      if (gaps && k % 3 == 2) begin
        @(posedge clk); #1;
      end
      if (k == H + 1) t_k = cyc;
      send(img[k], k == 0);
      if (k == 0) ign = 1'b0;
    end
    drain();
    check("count", n_out, N);
  endtask
  task automatic send_partial(input int n);
    ign = 1'b1;
    for (int k = 0; k < n; k++) send(img[k], k == 0);
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", in_ready, 1);
    check("rst_valid", out_valid, 0);
    check("rst_flags", {out_sof, out_eol, out_eof}, 0);
    check("rst_pixel", out_pixel, 0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) send(50, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    check("idle_discard", out_valid, 0);
    make_step(100, 100);
    drive_frame(1'b0);
    make_step(0, 255);
    drive_frame(1'b0);
    make_step(0, 20);
    drive_frame(1'b0);
    make_step(0, 40);
    drive_frame(1'b0);
    make_step(0, 255);
    nrdy = 0;
    drive_frame(1'b1);
    check("flush_cycles", nrdy, H + 1);
    send_partial(20);
    drive_frame(1'b0);
    send_partial(30);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("midrst_valid", out_valid, 0);
    check("midrst_ready", in_ready, 1);
    ign = 1'b0;
    drive_frame(1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
